// File: rtl/spi_reg_loader.sv
// SPI mode-0 write-only register loader: oversamples the pads, assembles 28-bit addr/data frames,
// and commits the last good frame on a frame-boundary strobe. Optional macro: SPI_REG_IMMEDIATE_EN.
module spi_reg_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_reg_csb,
    input  logic              i_reg_sclk,
    input  logic              i_reg_mosi,
    input  logic              i_load,
`ifdef SPI_REG_IMMEDIATE_EN
    input  logic              i_immediate,
`endif
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_pending
);
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = 6;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   csb_prev;
    logic                   sclk_prev;
    logic                   csb_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   csb_fall;

    logic [1:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_W-1:0]     shift_reg;
    logic [FRAME_W-1:0]     slot;
    logic                   pending;
    logic                   commit_now;
    logic                   load_fire;
    logic                   imm_req;

    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign csb_fall  = ~csb_s & csb_prev;

    assign commit_now = (state == S_COMMIT);
    assign load_fire  = i_load & pending;
`ifdef SPI_REG_IMMEDIATE_EN
    assign imm_req    = commit_now & i_immediate;
`else
    assign imm_req    = 1'b0;
`endif

    assign o_busy    = (state == S_SHIFT);
    assign o_pending = pending;

    // Pad synchronisers, reset to the idle bus levels
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            csb_sync  <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            csb_prev  <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], i_reg_csb};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_reg_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_reg_mosi};
            csb_prev  <= csb_s;
            sclk_prev <= sclk_s;
        end
    end

    // Frame assembly; the counter saturates so overlong frames can never alias back to 28
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (csb_fall) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (csb_s) begin
                        state <= (bit_cnt == FRAME_CNT) ? S_COMMIT : S_IDLE;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
                        if (bit_cnt != '1) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // A load in the COMMIT cycle drains the old slot first; the new frame then refills it.
    // An immediate frame colliding with a load falls back into the slot instead of being lost.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr    <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
            slot    <= '0;
            pending <= 1'b0;
        end else begin
            o_wr <= 1'b0;
            if (load_fire) begin
                o_wr    <= 1'b1;
                o_addr  <= slot[FRAME_W-1:DATA_W];
                o_data  <= slot[DATA_W-1:0];
                pending <= 1'b0;
            end else if (imm_req) begin
                o_wr   <= 1'b1;
                o_addr <= shift_reg[FRAME_W-1:DATA_W];
                o_data <= shift_reg[DATA_W-1:0];
            end
            if (commit_now && !(imm_req && !load_fire)) begin
                slot    <= shift_reg;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: doc/spi_reg_loader.md
Name: spi_reg_loader

Overview:
- Upstream feeder for the raycaster's register inputs; sits between the i_reg_csb/i_reg_sclk/i_reg_mosi pads and the core's register set.
- Oversamples an external SPI-mode-0 write-only link in the system clock domain.
- Assembles fixed 28-bit frames (4-bit address + 24-bit data) and holds the last good frame in a single pending slot.
- Commits the pending write to the core only on a frame-boundary strobe, so registers never change mid-frame.

Parameters:
- ADDR_W, 4, address field width.
- DATA_W, 24, data field width. Frame length is ADDR_W+DATA_W (28 by default).
- SYNC_STAGES, 2, flip-flop stages on each pad input (minimum 2).

Ports:
- i_clk  in  1  system clock. One clock only.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_reg_csb  in  1  SPI chip select, active-low, asynchronous to i_clk.
- i_reg_sclk  in  1  SPI clock, asynchronous to i_clk.
- i_reg_mosi  in  1  SPI data, asynchronous to i_clk.
- i_load  in  1  single-cycle frame-boundary strobe (end of vsync).
- o_wr  out  1  single-cycle commit pulse.
- o_addr  out  ADDR_W  committed address; valid when o_wr=1.
- o_data  out  DATA_W  committed data; valid when o_wr=1.
- o_busy  out  1  high while a frame is being shifted in (state SHIFT).
- o_pending  out  1  high when a good frame is waiting for i_load.

Behaviour:
- Reset (i_reset_n=0, asynchronous): all synchroniser flops go to idle levels (csb=1, sclk=0, mosi=0).
  - State=IDLE, bit count=0, shift register=0, pending slot empty.
  - o_wr=0, o_addr=0, o_data=0, o_busy=0, o_pending=0.
- Synchronisation: each pad passes through SYNC_STAGES flops.
  - SCLK rising edge = synced sclk is 1 and its previous sample was 0. MOSI is sampled on that same cycle.
  - SCLK must not exceed i_clk/4.
- Shifting: MSB first. The first 4 bits are the address; the remaining 24 are data.
- States:
  - IDLE: synced csb falls -> SHIFT, with count=0.
  - SHIFT: each sclk rise shifts in 1 bit and increments count (6-bit counter, saturates at 63).
    - csb rises with count==28 -> COMMIT.
    - csb rises with count!=28 -> IDLE; frame discarded, pending slot untouched.
  - COMMIT (1 cycle): the shift register is copied into the pending slot and o_pending=1 is set. Next state is IDLE.
    - If the slot was already full, it is overwritten (last write wins).
- Extra bits: more than 28 sclk rises make count!=28, so the frame is rejected. It is not truncated.
- Commit output: when i_load=1 and the slot is full, o_wr=1 for exactly one cycle on the next edge.
  - o_addr and o_data take the slot contents on that same edge.
  - o_pending clears on that same edge.
  - i_load with an empty slot has no effect.
- Simultaneous COMMIT and i_load in the same cycle: i_load consumes the old slot contents (o_wr with old values), and the new frame fills the slot. Result: o_pending stays 1.
- o_addr and o_data hold their values after o_wr deasserts.
- Reset mid-frame discards everything. After reset, the first frame is accepted only after a fresh csb fall.
- A csb glitch shorter than the synchroniser depth may be missed. That is acceptable behaviour.

Optional Feature:
- Macro: SPI_REG_IMMEDIATE_EN.
- Defined: adds input i_immediate (1 bit). When i_immediate=1, COMMIT drives o_wr directly on the following cycle and bypasses the pending slot. o_pending stays 0 for that frame.
- Not defined: the port is absent and every write waits for i_load.

Test Plan:
- Reset, then send frame addr=0x3, data=0xA5C3F0; pulse i_load 10 cycles later -> o_pending=1 until the load; then o_wr=1 for one cycle with o_addr=0x3, o_data=0xA5C3F0; then o_pending=0.
- Send a 27-bit frame and a 29-bit frame, then i_load -> o_wr stays 0 and o_pending stays 0.
- Send addr=0x1 data=0x000001, then addr=0x2 data=0x000002, then i_load -> exactly one o_wr, with addr=0x2 and data=0x000002.
- Align frame-2 COMMIT with i_load while frame-1 (0x5/0x123456) is pending -> o_wr carries 0x5/0x123456; o_pending stays 1; the next i_load gives frame 2.
- Drop i_reset_n after 14 bits of a frame, release it, then send full frame 0xF/0xFFFFFF -> only 0xF/0xFFFFFF is committed; no stale partial write.
- With SPI_REG_IMMEDIATE_EN and i_immediate=1, send 0x7/0x00BEEF -> o_wr=1 on the cycle after COMMIT without any i_load; o_pending stays 0.
